// File: rtl/cflog_ring.sv
// Circular control-flow log memory: self-zeroing after reset/clear, one or two
// entries per cycle, stop or wrap overflow policy, two registered read ports.
module cflog_ring #(
    parameter int DATA_W  = 16,
    parameter int DEPTH   = 512,
    parameter int ADDR_W  = 9,
    parameter int THRESH  = 510,
    parameter int WRAP_EN = 0
) (
    input  logic              ram_clk,
    input  logic              reset_n,
    input  logic              log_wen,
    input  logic              log_two,
    input  logic [DATA_W-1:0] log_din1,
    input  logic [DATA_W-1:0] log_din2,
    input  logic              log_clr,
    input  logic              sw_cen,
    input  logic [ADDR_W-1:0] sw_addr,
    output logic [DATA_W-1:0] sw_dout,
    input  logic [ADDR_W-1:0] hw_addr,
    output logic [DATA_W-1:0] hw_dout,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic [ADDR_W:0]   log_count,
    output logic              log_full,
    output logic              log_thresh,
    output logic              log_ovf,
    output logic              log_wrapped,
    output logic              busy,
    output logic [1:0]        o_dbg_state
);

    typedef enum logic [1:0] {
        ST_CLEAR = 2'd0,
        ST_RUN   = 2'd1,
        ST_FULL  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] DEPTH_C  = DEPTH[ADDR_W:0];
    localparam logic [ADDR_W:0] THRESH_C = THRESH[ADDR_W:0];
    localparam logic [ADDR_W:0] ONE_C    = {{ADDR_W{1'b0}}, 1'b1};
    localparam logic [ADDR_W:0] TWO_C    = {{(ADDR_W-1){1'b0}}, 2'd2};

    logic [DATA_W-1:0] r_mem [DEPTH];

    state_t            r_state;
    logic [ADDR_W-1:0] r_clr_idx;
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W:0]   r_count;
    logic              r_ovf;
    logic              r_wrapped;
    logic [DATA_W-1:0] r_sw_dout;
    logic [DATA_W-1:0] r_hw_dout;

    state_t            w_state_nxt;
    logic [ADDR_W-1:0] w_clr_idx_nxt;
    logic [ADDR_W-1:0] w_wr_ptr_nxt;
    logic [ADDR_W:0]   w_count_nxt;
    logic              w_ovf_nxt;
    logic              w_wrapped_nxt;
    logic              w_we0;
    logic              w_we1;
    logic [ADDR_W-1:0] w_wa0;
    logic [ADDR_W-1:0] w_wa1;
    logic [DATA_W-1:0] w_wd0;
    logic [DATA_W-1:0] w_wd1;

    // Modulo-DEPTH increments by compare-and-subtract; DEPTH need not be 2^n.
    logic [ADDR_W:0]   w_p1_ext;
    logic [ADDR_W-1:0] w_p1;
    logic [ADDR_W:0]   w_p2_ext;
    logic [ADDR_W-1:0] w_p2;
    logic [ADDR_W:0]   w_free;

    assign w_p1_ext = {1'b0, r_wr_ptr} + ONE_C;
    assign w_p1     = (w_p1_ext >= DEPTH_C) ? '0 : w_p1_ext[ADDR_W-1:0];
    assign w_p2_ext = {1'b0, w_p1} + ONE_C;
    assign w_p2     = (w_p2_ext >= DEPTH_C) ? '0 : w_p2_ext[ADDR_W-1:0];
    assign w_free   = DEPTH_C - r_count;

    always_comb begin
        w_state_nxt   = r_state;
        w_clr_idx_nxt = r_clr_idx;
        w_wr_ptr_nxt  = r_wr_ptr;
        w_count_nxt   = r_count;
        w_ovf_nxt     = r_ovf;
        w_wrapped_nxt = r_wrapped;
        w_we0         = 1'b0;
        w_we1         = 1'b0;
        w_wa0         = r_wr_ptr;
        w_wa1         = w_p1;
        w_wd0         = log_din1;
        w_wd1         = log_din2;

        case (r_state)
            ST_CLEAR: begin
                w_we0 = 1'b1;
                w_wa0 = r_clr_idx;
                w_wd0 = '0;
                if ({1'b0, r_clr_idx} == DEPTH_C - ONE_C) begin
                    w_state_nxt   = ST_RUN;
                    w_clr_idx_nxt = '0;
                end else begin
                    w_clr_idx_nxt = r_clr_idx + 1'b1;
                end
                if (log_wen) w_ovf_nxt = 1'b1;
            end
            ST_RUN: begin
                if (log_wen) begin
                    w_we0 = 1'b1;
                    if (WRAP_EN != 0) begin
                        w_we1        = log_two;
                        w_wr_ptr_nxt = log_two ? w_p2 : w_p1;
                        if (log_two) begin
                            // The second entry overwrites if the first one fills the log.
                            if (r_count >= DEPTH_C - ONE_C) begin
                                w_count_nxt   = DEPTH_C;
                                w_wrapped_nxt = 1'b1;
                            end else begin
                                w_count_nxt = r_count + TWO_C;
                            end
                        end else if (r_count == DEPTH_C) begin
                            w_wrapped_nxt = 1'b1;
                        end else begin
                            w_count_nxt = r_count + ONE_C;
                        end
                    end else begin
                        // RUN in stop mode always has at least one free slot.
                        if (log_two && (w_free >= TWO_C)) begin
                            w_we1        = 1'b1;
                            w_wr_ptr_nxt = w_p2;
                            w_count_nxt  = r_count + TWO_C;
                        end else begin
                            w_wr_ptr_nxt = w_p1;
                            w_count_nxt  = r_count + ONE_C;
                            if (log_two) w_ovf_nxt = 1'b1;
                        end
                        if (w_count_nxt == DEPTH_C) w_state_nxt = ST_FULL;
                    end
                end
            end
            ST_FULL: begin
                if (log_wen) w_ovf_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = ST_CLEAR;
            end
        endcase

        if (log_clr) begin
            w_state_nxt   = ST_CLEAR;
            w_clr_idx_nxt = '0;
            w_wr_ptr_nxt  = '0;
            w_count_nxt   = '0;
            w_ovf_nxt     = 1'b0;
            w_wrapped_nxt = 1'b0;
            w_we0         = 1'b0;
            w_we1         = 1'b0;
        end
    end

    always_ff @(posedge ram_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= ST_CLEAR;
            r_clr_idx <= '0;
            r_wr_ptr  <= '0;
            r_count   <= '0;
            r_ovf     <= 1'b0;
            r_wrapped <= 1'b0;
            r_sw_dout <= '0;
            r_hw_dout <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_clr_idx <= w_clr_idx_nxt;
            r_wr_ptr  <= w_wr_ptr_nxt;
            r_count   <= w_count_nxt;
            r_ovf     <= w_ovf_nxt;
            r_wrapped <= w_wrapped_nxt;
            r_sw_dout <= (sw_cen || ({1'b0, sw_addr} >= DEPTH_C)) ? '0 : r_mem[sw_addr];
            r_hw_dout <= ({1'b0, hw_addr} >= DEPTH_C) ? '0 : r_mem[hw_addr];
        end
    end

    // Storage is left unreset so it maps to block RAM; the CLEAR sweep zeroes it.
    always_ff @(posedge ram_clk) begin
        if (w_we0) r_mem[w_wa0] <= w_wd0;
        if (w_we1) r_mem[w_wa1] <= w_wd1;
    end

    assign sw_dout     = r_sw_dout;
    assign hw_dout     = r_hw_dout;
    assign wr_ptr      = r_wr_ptr;
    assign log_count   = r_count;
    assign log_full    = (r_count == DEPTH_C);
    assign log_thresh  = (r_count >= THRESH_C);
    assign log_ovf     = r_ovf;
    assign log_wrapped = r_wrapped;
    assign busy        = (r_state == ST_CLEAR);
    assign o_dbg_state = r_state;

endmodule

// File: tb/tb_cflog_ring.sv
// Directed bench for cflog_ring: one stop-mode and one wrap-mode instance
// (DEPTH=8, THRESH=6) sharing clock, reset, data and read-address inputs.
module tb_cflog_ring;

    logic        ram_clk = 1'b0;
    logic        reset_n;
    logic        log_two;
    logic [15:0] log_din1;
    logic [15:0] log_din2;
    logic        sw_cen;
    logic [2:0]  sw_addr;
    logic [2:0]  hw_addr;

    logic        wen_s, wen_w, clr_s, clr_w;
    logic [15:0] sw_dout_s, sw_dout_w, hw_dout_s, hw_dout_w;
    logic [2:0]  wr_ptr_s, wr_ptr_w;
    logic [3:0]  count_s, count_w;
    logic        full_s, full_w, thresh_s, thresh_w;
    logic        ovf_s, ovf_w, wrapped_s, wrapped_w, busy_s, busy_w;
    logic [1:0]  dbg_s, dbg_w;

    int total = 0;
    int bad   = 0;
    logic [15:0] exp_q[$];

    always #5 ram_clk = ~ram_clk;

    cflog_ring #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .THRESH(6), .WRAP_EN(0)) dut_stop (
        .ram_clk(ram_clk), .reset_n(reset_n), .log_wen(wen_s), .log_two(log_two),
        .log_din1(log_din1), .log_din2(log_din2), .log_clr(clr_s),
        .sw_cen(sw_cen), .sw_addr(sw_addr), .sw_dout(sw_dout_s),
        .hw_addr(hw_addr), .hw_dout(hw_dout_s), .wr_ptr(wr_ptr_s),
        .log_count(count_s), .log_full(full_s), .log_thresh(thresh_s),
        .log_ovf(ovf_s), .log_wrapped(wrapped_s), .busy(busy_s), .o_dbg_state(dbg_s)
    );

    cflog_ring #(.DATA_W(16), .DEPTH(8), .ADDR_W(3), .THRESH(6), .WRAP_EN(1)) dut_wrap (
        .ram_clk(ram_clk), .reset_n(reset_n), .log_wen(wen_w), .log_two(log_two),
        .log_din1(log_din1), .log_din2(log_din2), .log_clr(clr_w),
        .sw_cen(sw_cen), .sw_addr(sw_addr), .sw_dout(sw_dout_w),
        .hw_addr(hw_addr), .hw_dout(hw_dout_w), .wr_ptr(wr_ptr_w),
        .log_count(count_w), .log_full(full_w), .log_thresh(thresh_w),
        .log_ovf(ovf_w), .log_wrapped(wrapped_w), .busy(busy_w), .o_dbg_state(dbg_w)
    );

    // Drivers: every task starts and ends on a falling edge.
    task automatic write_entry(input bit sel, input bit two, input logic [15:0] d1,
                               input logic [15:0] d2);
        log_two  = two;
        log_din1 = d1;
        log_din2 = d2;
        if (sel) wen_w = 1'b1; else wen_s = 1'b1;
        @(negedge ram_clk);
        wen_s   = 1'b0;
        wen_w   = 1'b0;
        log_two = 1'b0;
    endtask

    task automatic pulse_clr(input bit sel);
        if (sel) clr_w = 1'b1; else clr_s = 1'b1;
        @(negedge ram_clk);
        clr_s = 1'b0;
        clr_w = 1'b0;
    endtask

    task automatic sw_read(input bit sel, input logic [2:0] addr, input bit cen,
                           output logic [15:0] data);
        sw_addr = addr;
        sw_cen  = cen;
        @(negedge ram_clk);
        data   = sel ? sw_dout_w : sw_dout_s;
        sw_cen = 1'b1;
    endtask

    // Counts falling-edge samples with busy high, bounded at 40.
    task automatic count_busy(input bit sel, output int n);
        n = 0;
        while ((sel ? busy_w : busy_s) && n < 40) begin
            n++;
            @(negedge ram_clk);
        end
    endtask

    task automatic test_reset();
        logic [15:0] d;
        int n;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(negedge ram_clk);
        total++; if (busy_s !== 1'b1 || busy_w !== 1'b1) begin bad++; $display("FAIL reset_busy got=%b%b exp=11", busy_s, busy_w); end
        total++; if (count_s !== 4'd0 || wr_ptr_s !== 3'd0 || ovf_s !== 1'b0 || wrapped_w !== 1'b0) begin bad++; $display("FAIL reset_regs cnt=%0d ptr=%0d ovf=%b wrp=%b exp=0", count_s, wr_ptr_s, ovf_s, wrapped_w); end
        total++; if (full_s !== 1'b0 || thresh_s !== 1'b0 || sw_dout_s !== 16'h0 || hw_dout_w !== 16'h0) begin bad++; $display("FAIL reset_outs full=%b thr=%b sw=%h hw=%h exp=0", full_s, thresh_s, sw_dout_s, hw_dout_w); end
        reset_n = 1'b1;
        count_busy(1'b0, n);
        total++; if (n !== 8) begin bad++; $display("FAIL reset_busy_cycles got=%0d exp=8", n); end
        total++; if (busy_w !== 1'b0 || count_w !== 4'd0) begin bad++; $display("FAIL reset_wrap_done busy=%b cnt=%0d exp=0", busy_w, count_w); end
        for (int a = 0; a < 8; a++) begin
            sw_read(1'b0, a[2:0], 1'b0, d);
            total++; if (d !== 16'h0000) begin bad++; $display("FAIL reset_zero addr=%0d got=%h exp=0000", a, d); end
        end
    endtask

    task automatic test_stop_fill();
        logic [15:0] d;
        for (int i = 0; i < 3; i++) write_entry(1'b0, 1'b1, 16'h1111, 16'h2222);
        write_entry(1'b0, 1'b0, 16'h3333, 16'h0000);
        total++; if (wr_ptr_s !== 3'd7 || count_s !== 4'd7) begin bad++; $display("FAIL fill_ptr_cnt ptr=%0d cnt=%0d exp=7,7", wr_ptr_s, count_s); end
        total++; if (thresh_s !== 1'b1 || full_s !== 1'b0 || ovf_s !== 1'b0) begin bad++; $display("FAIL fill_flags thr=%b full=%b ovf=%b exp=1,0,0", thresh_s, full_s, ovf_s); end
        sw_read(1'b0, 3'd6, 1'b0, d);
        total++; if (d !== 16'h3333) begin bad++; $display("FAIL fill_sw6 got=%h exp=3333", d); end
        sw_read(1'b0, 3'd6, 1'b1, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL fill_sw_cen_hi got=%h exp=0000", d); end
        sw_read(1'b0, 3'd5, 1'b0, d);
        total++; if (d !== 16'h2222) begin bad++; $display("FAIL fill_sw5 got=%h exp=2222", d); end
        hw_addr = 3'd4;
        @(negedge ram_clk);
        total++; if (hw_dout_s !== 16'h1111) begin bad++; $display("FAIL fill_hw4 got=%h exp=1111", hw_dout_s); end
    endtask

    task automatic test_stop_overflow();
        logic [15:0] d;
        write_entry(1'b0, 1'b1, 16'hAAAA, 16'hBBBB);
        total++; if (full_s !== 1'b1 || ovf_s !== 1'b1 || count_s !== 4'd8 || wr_ptr_s !== 3'd0) begin bad++; $display("FAIL ovf_flags full=%b ovf=%b cnt=%0d ptr=%0d exp=1,1,8,0", full_s, ovf_s, count_s, wr_ptr_s); end
        sw_read(1'b0, 3'd7, 1'b0, d);
        total++; if (d !== 16'hAAAA) begin bad++; $display("FAIL ovf_mem7 got=%h exp=AAAA", d); end
        write_entry(1'b0, 1'b0, 16'h5555, 16'h0000);
        sw_read(1'b0, 3'd0, 1'b0, d);
        total++; if (d !== 16'h1111) begin bad++; $display("FAIL full_mem0 got=%h exp=1111", d); end
        total++; if (wr_ptr_s !== 3'd0 || count_s !== 4'd8 || dbg_s !== 2'd2) begin bad++; $display("FAIL full_hold ptr=%0d cnt=%0d st=%0d exp=0,8,2", wr_ptr_s, count_s, dbg_s); end
    endtask

    task automatic test_wrap_singles();
        logic [15:0] d;
        logic [15:0] e;
        for (int v = 1; v <= 9; v++) write_entry(1'b1, 1'b0, v[15:0], 16'h0000);
        total++; if (wr_ptr_w !== 3'd1 || count_w !== 4'd8) begin bad++; $display("FAIL wrap_ptr_cnt ptr=%0d cnt=%0d exp=1,8", wr_ptr_w, count_w); end
        total++; if (wrapped_w !== 1'b1 || ovf_w !== 1'b0 || full_w !== 1'b1) begin bad++; $display("FAIL wrap_flags wrp=%b ovf=%b full=%b exp=1,0,1", wrapped_w, ovf_w, full_w); end
        exp_q = {16'd9, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'd8};
        for (int a = 0; a < 8; a++) begin
            sw_read(1'b1, a[2:0], 1'b0, d);
            e = exp_q.pop_front();
            total++; if (d !== e) begin bad++; $display("FAIL wrap_mem addr=%0d got=%h exp=%h", a, d, e); end
        end
    endtask

    task automatic test_wrap_pair();
        logic [15:0] d;
        int n;
        pulse_clr(1'b1);
        write_entry(1'b1, 1'b0, 16'hDEAD, 16'h0000);
        total++; if (ovf_w !== 1'b1) begin bad++; $display("FAIL clear_wen_ovf got=%b exp=1", ovf_w); end
        count_busy(1'b1, n);
        total++; if (n !== 7) begin bad++; $display("FAIL clear_wen_busy_left got=%0d exp=7", n); end
        pulse_clr(1'b1);
        total++; if (ovf_w !== 1'b0 || busy_w !== 1'b1) begin bad++; $display("FAIL clr_clears_ovf ovf=%b busy=%b exp=0,1", ovf_w, busy_w); end
        count_busy(1'b1, n);
        for (int v = 1; v <= 7; v++) write_entry(1'b1, 1'b0, v[15:0], 16'h0000);
        total++; if (wr_ptr_w !== 3'd7 || count_w !== 4'd7 || wrapped_w !== 1'b0) begin bad++; $display("FAIL pair_pre ptr=%0d cnt=%0d wrp=%b exp=7,7,0", wr_ptr_w, count_w, wrapped_w); end
        write_entry(1'b1, 1'b1, 16'hC0DE, 16'hBEEF);
        total++; if (wr_ptr_w !== 3'd1 || count_w !== 4'd8 || wrapped_w !== 1'b1 || ovf_w !== 1'b0) begin bad++; $display("FAIL pair_flags ptr=%0d cnt=%0d wrp=%b ovf=%b exp=1,8,1,0", wr_ptr_w, count_w, wrapped_w, ovf_w); end
        sw_read(1'b1, 3'd7, 1'b0, d);
        total++; if (d !== 16'hC0DE) begin bad++; $display("FAIL pair_mem7 got=%h exp=C0DE", d); end
        sw_read(1'b1, 3'd0, 1'b0, d);
        total++; if (d !== 16'hBEEF) begin bad++; $display("FAIL pair_mem0 got=%h exp=BEEF", d); end
    endtask

    task automatic test_clr_priority();
        logic [15:0] d;
        int n;
        clr_s    = 1'b1;
        wen_s    = 1'b1;
        log_din1 = 16'h7777;
        @(negedge ram_clk);
        clr_s = 1'b0;
        wen_s = 1'b0;
        total++; if (busy_s !== 1'b1 || ovf_s !== 1'b0 || count_s !== 4'd0 || wr_ptr_s !== 3'd0 || full_s !== 1'b0) begin bad++; $display("FAIL clr_state busy=%b ovf=%b cnt=%0d ptr=%0d full=%b exp=1,0,0,0,0", busy_s, ovf_s, count_s, wr_ptr_s, full_s); end
        count_busy(1'b0, n);
        total++; if (n !== 8) begin bad++; $display("FAIL clr_busy_cycles got=%0d exp=8", n); end
        total++; if (count_s !== 4'd0 || ovf_s !== 1'b0) begin bad++; $display("FAIL clr_after cnt=%0d ovf=%b exp=0,0", count_s, ovf_s); end
        sw_read(1'b0, 3'd7, 1'b0, d);
        total++; if (d !== 16'h0000) begin bad++; $display("FAIL clr_zero7 got=%h exp=0000", d); end
    endtask

    task automatic test_reset_mid_clear();
        int n;
        write_entry(1'b0, 1'b1, 16'h4242, 16'h4343);
        pulse_clr(1'b0);
        repeat (3) @(negedge ram_clk);
        reset_n = 1'b0;
        @(negedge ram_clk);
        total++; if (busy_s !== 1'b1 || count_s !== 4'd0) begin bad++; $display("FAIL midclr_reset busy=%b cnt=%0d exp=1,0", busy_s, count_s); end
        @(negedge ram_clk);
        reset_n = 1'b1;
        count_busy(1'b0, n);
        total++; if (n !== 8) begin bad++; $display("FAIL midclr_busy_cycles got=%0d exp=8", n); end
        write_entry(1'b0, 1'b0, 16'h9999, 16'h0000);
        total++; if (wr_ptr_s !== 3'd1 || count_s !== 4'd1) begin bad++; $display("FAIL midclr_run ptr=%0d cnt=%0d exp=1,1", wr_ptr_s, count_s); end
    endtask

    initial begin
        wen_s    = 1'b0;
        wen_w    = 1'b0;
        clr_s    = 1'b0;
        clr_w    = 1'b0;
        log_two  = 1'b0;
        log_din1 = '0;
        log_din2 = '0;
        sw_cen   = 1'b1;
        sw_addr  = '0;
        hw_addr  = '0;
        test_reset();
        test_stop_fill();
        test_stop_overflow();
        test_wrap_singles();
        test_wrap_pair();
        test_clr_priority();
        test_reset_mid_clear();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
